// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage -- instruction decode stage of a five-stage pipeline.
//
// Decodes the instruction held in the IF/ID latch. Reads two operands from a
// 32x32 register file, with write-back forwarding inside the same cycle.
// Sign-extends the immediate and registers everything into the ID/EX latch.
// A stall or flush turns the latched instruction into a bubble: all control
// fields are cleared and idex_valid is low.
//
// Optional feature (compile-time macro ID_HAZARD_EN):
//   defined   -> stall is raised when the instruction in EX is a load whose
//                rt matches this instruction's rs or rt (load-use hazard).
//   undefined -> stall is tied low and ex_memread / ex_rt are ignored.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   instr, npc          instruction and PC+1 from IF/ID
//   wb_we/addr/data     register-file write port from write-back
//   ex_memread, ex_rt   load indication and destination of the EX instruction
//   flush               squash the current ID instruction
//   stall               combinational: hold PC and IF/ID this cycle
//   idex_*              registered ID/EX latch contents
// ---------------------------------------------------------------------------
module id_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr,
    input  logic [DW-1:0] npc,
    input  logic          wb_we,
    input  logic [4:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          ex_memread,
    input  logic [4:0]    ex_rt,
    input  logic          flush,
    output logic          stall,
    output logic [DW-1:0] idex_npc,
    output logic [DW-1:0] idex_rd1,
    output logic [DW-1:0] idex_rd2,
    output logic [DW-1:0] idex_imm,
    output logic [4:0]    idex_rt,
    output logic [4:0]    idex_rd,
    output logic [1:0]    idex_wb,
    output logic [2:0]    idex_m,
    output logic [3:0]    idex_ex,
    output logic          idex_valid
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [DW-1:0] regs_r [0:31];

    logic [5:0]    opcode_s;
    logic [4:0]    rs_s;
    logic [4:0]    rt_s;
    logic [4:0]    rd_s;
    logic [DW-1:0] rd1_s;
    logic [DW-1:0] rd2_s;
    logic [DW-1:0] imm_s;
    logic [1:0]    wb_ctl_s;
    logic [2:0]    m_ctl_s;
    logic [3:0]    ex_ctl_s;
    logic          bubble_s;
    logic          wb_fire_s;

    assign opcode_s  = instr[31:26];
    assign rs_s      = instr[25:21];
    assign rt_s      = instr[20:16];
    assign rd_s      = instr[15:11];
    assign imm_s     = {{(DW-16){instr[15]}}, instr[15:0]};
    assign wb_fire_s = wb_we && (wb_addr != 5'd0);

    // Register file write port; register 0 is never written so it reads as 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_fire_s) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Operand reads with same-cycle forwarding of the write-back value.
    always_comb begin
        rd1_s = '0;
        rd2_s = '0;
        if (rs_s == 5'd0) begin
            rd1_s = '0;
        end else if (wb_fire_s && (wb_addr == rs_s)) begin
            rd1_s = wb_data;
        end else begin
            rd1_s = regs_r[rs_s];
        end
        if (rt_s == 5'd0) begin
            rd2_s = '0;
        end else if (wb_fire_s && (wb_addr == rt_s)) begin
            rd2_s = wb_data;
        end else begin
            rd2_s = regs_r[rt_s];
        end
    end

    // Main control decode; unknown opcodes decode as a NOP with no side effects.
    always_comb begin
        wb_ctl_s = 2'b00;
        m_ctl_s  = 3'b000;
        ex_ctl_s = 4'b0000;
        case (opcode_s)
            OP_RTYPE: begin
                wb_ctl_s = 2'b10;
                m_ctl_s  = 3'b000;
                ex_ctl_s = 4'b1100;
            end
            OP_LW: begin
                wb_ctl_s = 2'b11;
                m_ctl_s  = 3'b010;
                ex_ctl_s = 4'b0001;
            end
            OP_SW: begin
                wb_ctl_s = 2'b00;
                m_ctl_s  = 3'b001;
                ex_ctl_s = 4'b0001;
            end
            OP_BEQ: begin
                wb_ctl_s = 2'b00;
                m_ctl_s  = 3'b100;
                ex_ctl_s = 4'b0010;
            end
            OP_ADDI: begin
                wb_ctl_s = 2'b10;
                m_ctl_s  = 3'b000;
                ex_ctl_s = 4'b0001;
            end
            default: begin
                wb_ctl_s = 2'b00;
                m_ctl_s  = 3'b000;
                ex_ctl_s = 4'b0000;
            end
        endcase
    end

`ifdef ID_HAZARD_EN
    // Load-use hazard: the EX load's result is not ready for this instruction.
    always_comb begin
        stall = 1'b0;
        if (ex_memread && (ex_rt != 5'd0) && ((ex_rt == rs_s) || (ex_rt == rt_s))) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end
`else
    logic unused_hazard_s;
    assign unused_hazard_s = ex_memread ^ (^ex_rt);
    assign stall = 1'b0;
`endif

    assign bubble_s = stall || flush;

    // ID/EX latch; a bubble keeps the data fields but drops all control.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_npc   <= '0;
            idex_rd1   <= '0;
            idex_rd2   <= '0;
            idex_imm   <= '0;
            idex_rt    <= 5'd0;
            idex_rd    <= 5'd0;
            idex_wb    <= 2'b00;
            idex_m     <= 3'b000;
            idex_ex    <= 4'b0000;
            idex_valid <= 1'b0;
        end else begin
            idex_npc <= npc;
            idex_rd1 <= rd1_s;
            idex_rd2 <= rd2_s;
            idex_imm <= imm_s;
            idex_rt  <= rt_s;
            idex_rd  <= rd_s;
            if (bubble_s) begin
                idex_wb    <= 2'b00;
                idex_m     <= 3'b000;
                idex_ex    <= 4'b0000;
                idex_valid <= 1'b0;
            end else begin
                idex_wb    <= wb_ctl_s;
                idex_m     <= m_ctl_s;
                idex_ex    <= ex_ctl_s;
                idex_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// ---------------------------------------------------------------------------
// tb_id_stage -- directed, table-driven bench for id_stage.
// Each table row drives one cycle of inputs and holds hand-computed expected
// ID/EX contents for the following edge. The register state carries over
// from row to row. Hazard rows expect a stall only when ID_HAZARD_EN is
// defined. Hand-written sequences cover reset at start and reset mid-run.
// ---------------------------------------------------------------------------
module tb_id_stage;

`ifdef ID_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        flush;
    logic        stall;
    logic [31:0] idex_npc;
    logic [31:0] idex_rd1;
    logic [31:0] idex_rd2;
    logic [31:0] idex_imm;
    logic [4:0]  idex_rt;
    logic [4:0]  idex_rd;
    logic [1:0]  idex_wb;
    logic [2:0]  idex_m;
    logic [3:0]  idex_ex;
    logic        idex_valid;

    int n_checks;
    int n_fail;

    id_stage #(.DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .npc        (npc),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .flush      (flush),
        .stall      (stall),
        .idex_npc   (idex_npc),
        .idex_rd1   (idex_rd1),
        .idex_rd2   (idex_rd2),
        .idex_imm   (idex_imm),
        .idex_rt    (idex_rt),
        .idex_rd    (idex_rd),
        .idex_wb    (idex_wb),
        .idex_m     (idex_m),
        .idex_ex    (idex_ex),
        .idex_valid (idex_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        flush;
        logic        ex_memread;
        logic [4:0]  ex_rt;
        logic        e_stall;
        logic        e_valid;
        logic [1:0]  e_wb;
        logic [2:0]  e_m;
        logic [3:0]  e_ex;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_imm;
        logic [4:0]  e_rt;
        logic [4:0]  e_rd;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".npc"},   idex_npc, 32'h0);
        chk({tag, ".rd1"},   idex_rd1, 32'h0);
        chk({tag, ".rd2"},   idex_rd2, 32'h0);
        chk({tag, ".imm"},   idex_imm, 32'h0);
        chk({tag, ".rt"},    {27'd0, idex_rt}, 32'h0);
        chk({tag, ".rd"},    {27'd0, idex_rd}, 32'h0);
        chk({tag, ".ctl"},   {20'd0, idex_wb, idex_m, idex_ex}, 32'h0);
        chk({tag, ".valid"}, {31'd0, idex_valid}, 32'h0);
    endtask

    task automatic idle_inputs();
        instr      = 32'h0;
        npc        = 32'h0;
        wb_we      = 1'b0;
        wb_addr    = 5'd0;
        wb_data    = 32'h0;
        flush      = 1'b0;
        ex_memread = 1'b0;
        ex_rt      = 5'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //          instr         npc    we    wa     wdata          fl    mr    ert    stall  valid  wb              m                 ex                  rd1           rd2           imm           rt     rd
        vecs[0]  = '{32'h00000000, 32'd1, 1'b1, 5'd5,  32'h00001234, 1'b0, 1'b0, 5'd0,  1'b0,  1'b1,  2'b10,          3'b000,           4'b1100,            32'h0,        32'h0,        32'h0,        5'd0,  5'd0};
        vecs[1]  = '{32'h00A62020, 32'd2, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b0,  1'b1,  2'b10,          3'b000,           4'b1100,            32'h00001234, 32'h0,        32'h00002020, 5'd6,  5'd4};
        vecs[2]  = '{32'h00E83020, 32'd3, 1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 1'b0, 5'd0,  1'b0,  1'b1,  2'b10,          3'b000,           4'b1100,            32'hDEADBEEF, 32'h0,        32'h00003020, 5'd8,  5'd6};
        vecs[3]  = '{32'h8C22FFFC, 32'd4, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 5'd0,  1'b0,  1'b1,  2'b11,          3'b010,           4'b0001,            32'h0,        32'h0,        32'hFFFFFFFC, 5'd2,  5'd31};
        vecs[4]  = '{32'hAC070010, 32'd5, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b0,  1'b1,  2'b00,          3'b001,           4'b0001,            32'h0,        32'hDEADBEEF, 32'h00000010, 5'd7,  5'd0};
        vecs[5]  = '{32'h10A70003, 32'd6, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  1'b0,  1'b0,  2'b00,          3'b000,           4'b0000,            32'h00001234, 32'hDEADBEEF, 32'h00000003, 5'd7,  5'd0};
        vecs[6]  = '{32'h10A70003, 32'd7, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b0,  1'b1,  2'b00,          3'b100,           4'b0010,            32'h00001234, 32'hDEADBEEF, 32'h00000003, 5'd7,  5'd0};
        vecs[7]  = '{32'h20A9FFFF, 32'd8, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd5,  HZ,    !HZ,   HZ ? 2'b00 : 2'b10, 3'b000,        HZ ? 4'b0000 : 4'b0001, 32'h00001234, 32'h0,    32'hFFFFFFFF, 5'd9,  5'd31};
        vecs[8]  = '{32'hFC210005, 32'd9, 1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  1'b0,  1'b1,  2'b00,          3'b000,           4'b0000,            32'h0,        32'h0,        32'h00000005, 5'd1,  5'd0};
        vecs[9]  = '{32'h20640001, 32'd10, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd3,  HZ,    !HZ,   HZ ? 2'b00 : 2'b10, 3'b000,        HZ ? 4'b0000 : 4'b0001, 32'h0,     32'h0,        32'h00000001, 5'd4,  5'd0};
        vecs[10] = '{32'h00000000, 32'd11, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 5'd0,  1'b0,  1'b1,  2'b10,          3'b000,           4'b1100,            32'h0,        32'h0,        32'h0,        5'd0,  5'd0};
        vecs[11] = '{32'h20640001, 32'd12, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd4,  HZ,    1'b0,  2'b00,          3'b000,           4'b0000,            32'h0,        32'h0,        32'h00000001, 5'd4,  5'd0};
        vecs[12] = '{32'h001F0000, 32'd13, 1'b1, 5'd31, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd0, 1'b0,  1'b1,  2'b10,          3'b000,           4'b1100,            32'h0,        32'hA5A5A5A5, 32'h0,        5'd31, 5'd0};
        vecs[13] = '{32'h03E00000, 32'd14, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 5'd0,  1'b0,  1'b1,  2'b10,          3'b000,           4'b1100,            32'hA5A5A5A5, 32'h0,        32'h0,        5'd0,  5'd0};

        // Power-on reset: outputs clear with a clock edge inside reset.
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("por");
        reset = 1'b0;

        // Table-driven vectors: drive at negedge, sample 1 after the edge.
        for (int i = 0; i < NV; i++) begin
            instr      = vecs[i].instr;
            npc        = vecs[i].npc;
            wb_we      = vecs[i].wb_we;
            wb_addr    = vecs[i].wb_addr;
            wb_data    = vecs[i].wb_data;
            flush      = vecs[i].flush;
            ex_memread = vecs[i].ex_memread;
            ex_rt      = vecs[i].ex_rt;
            #1;
            chk($sformatf("v%0d.stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", i), {31'd0, idex_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("v%0d.wb", i),    {30'd0, idex_wb},    {30'd0, vecs[i].e_wb});
            chk($sformatf("v%0d.m", i),     {29'd0, idex_m},     {29'd0, vecs[i].e_m});
            chk($sformatf("v%0d.ex", i),    {28'd0, idex_ex},    {28'd0, vecs[i].e_ex});
            chk($sformatf("v%0d.npc", i),   idex_npc,            vecs[i].npc);
            chk($sformatf("v%0d.rd1", i),   idex_rd1,            vecs[i].e_rd1);
            chk($sformatf("v%0d.rd2", i),   idex_rd2,            vecs[i].e_rd2);
            chk($sformatf("v%0d.imm", i),   idex_imm,            vecs[i].e_imm);
            chk($sformatf("v%0d.rt", i),    {27'd0, idex_rt},    {27'd0, vecs[i].e_rt});
            chk($sformatf("v%0d.rd", i),    {27'd0, idex_rd},    {27'd0, vecs[i].e_rd});
            @(negedge clk);
        end

        // Mid-run reset: load a real lw, then assert reset between edges.
        idle_inputs();
        instr = 32'h8C22FFFC;
        npc   = 32'd99;
        @(posedge clk);
        #1;
        chk("mid.pre_valid", {31'd0, idex_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("mid.async");
        // A write attempted during reset must be discarded.
        wb_we   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid.held");
        reset   = 1'b0;
        wb_we   = 1'b0;
        wb_addr = 5'd0;
        wb_data = 32'h0;
        instr   = 32'h00A70000;
        npc     = 32'd100;
        @(posedge clk);
        #1;
        chk("post.rd1_r5", idex_rd1, 32'h0);
        chk("post.rd2_r7", idex_rd2, 32'h0);
        chk("post.valid", {31'd0, idex_valid}, 32'd1);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter DW, default 32, meaning datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr  input  32  instruction from the IF/ID latch.
REQ-005 SHALL have port npc  input  32  PC+1 from the IF/ID latch.
REQ-006 SHALL have port wb_we  input  1  register-file write enable from write-back.
REQ-007 SHALL have port wb_addr  input  5  write-back destination register.
REQ-008 SHALL have port wb_data  input  32  write-back data.
REQ-009 SHALL have port ex_memread  input  1  instruction currently in EX is a load.
REQ-010 SHALL have port ex_rt  input  5  destination rt of the instruction in EX.
REQ-011 SHALL have port flush  input  1  squash the current ID instruction (taken branch).
REQ-012 SHALL have port stall  output  1  hold PC and IF/ID latch this cycle.
REQ-013 SHALL have ports idex_npc, idex_rd1, idex_rd2, idex_imm  output  32 each: latched npc, rs data, rt data, sign-extended imm.
REQ-014 SHALL have ports idex_rt, idex_rd  output  5 each: instr[20:16], instr[15:11].
REQ-015 SHALL have ports idex_wb  output  2 {regwrite,memtoreg}; idex_m  output  3 {branch,memread,memwrite}; idex_ex  output  4 {regdst,aluop[1:0],alusrc}.
REQ-016 SHALL have port idex_valid  output  1  high when ID/EX holds a real instruction, low for a bubble.

Function
REQ-017 SHALL contain a 32x32 register file; reg 0 reads 0 always, writes to it ignored.
REQ-018 SHALL write the register file on clk rising edge when wb_we=1 and wb_addr!=0.
REQ-019 SHALL bypass: when wb_we=1, wb_addr!=0 and wb_addr equals rs (rt), rd1 (rd2) read returns wb_data in the same cycle.
REQ-020 SHALL decode opcode instr[31:26]: 0x00 R-type wb=11? no: wb=10, m=000, ex=1_10_0; 0x23 lw wb=11, m=010, ex=0_00_1; 0x2B sw wb=00, m=001, ex=0_00_1; 0x04 beq wb=00, m=100, ex=0_01_0; 0x08 addi wb=10, m=000, ex=0_00_1.
REQ-021 SHALL treat any other opcode as NOP: all control fields 0, idex_valid=1.
REQ-022 SHALL sign-extend instr[15:0] to 32 bits for idex_imm.
REQ-023 SHALL register all idex_* outputs on each clk rising edge; latency one cycle from instr to idex_*.
REQ-024 SHALL drive stall combinationally (see REQ-031) and, when stall=1, load a bubble: idex_wb, idex_m, idex_ex=0, idex_valid=0, data fields don't-care but deterministic (latched as normal).
REQ-025 SHALL, when flush=1, load a bubble as in REQ-024 regardless of stall; stall is still driven per REQ-031.
REQ-026 SHALL give register-file write (REQ-018) priority independent of stall/flush; writes never blocked.
REQ-027 SHALL treat an all-zero instr as R-type sll $0 (regwrite to $0 has no effect).

Reset
REQ-028 SHALL, on reset=1, immediately clear all idex_* outputs to 0 and idex_valid to 0, without waiting for clk.
REQ-029 SHALL clear all 32 registers to 0 on reset.
REQ-030 SHALL ignore wb_we while reset=1; a reset asserted mid-operation discards the in-flight ID/EX contents.

Configuration
REQ-031 SHALL, with ID_HAZARD_EN defined, set stall=1 when ex_memread=1, ex_rt!=0 and ex_rt equals instr[25:21] or instr[20:16], else 0.
REQ-032 SHALL, with ID_HAZARD_EN undefined, tie stall=0 and ignore ex_memread/ex_rt; no bubble arises from hazards.

Verification
REQ-033 SHALL cover: reset mid-run -> all idex_* =0, idex_valid=0 asynchronously; regs read 0 afterwards.
REQ-034 SHALL cover: wb write $5=0x0000_1234, next cycle instr=0x00A62020 (add $4,$5,$6) -> idex_rd1=0x1234, idex_wb=10, idex_ex=1100, idex_rd=4.
REQ-035 SHALL cover: same-cycle wb_we=1, wb_addr=7, wb_data=0xDEADBEEF with instr reading rs=$7 -> idex_rd1=0xDEADBEEF.
REQ-036 SHALL cover: instr=0x8C22FFFC (lw $2,-4($1)) -> idex_imm=0xFFFFFFFC, idex_m=010, idex_wb=11; wb to $0 then read $0 -> 0.
REQ-037 SHALL cover (ID_HAZARD_EN): ex_memread=1, ex_rt=3, instr rs=3 -> stall=1, next idex_valid=0, controls 0; ex_rt=0 -> stall=0.
REQ-038 SHALL cover: flush=1 with valid beq instr -> next idex_valid=0, idex_m=000; unknown opcode 0x3F -> controls 0, idex_valid=1.
